// File: rtl/seq_gen_pkg.sv
// Shared constants, state encoding and helpers for the serial pattern generator.
package seq_gen_pkg;

  localparam logic [3:0] SEQ_1100 = 4'b1100;
  localparam logic [3:0] SEQ_1010 = 4'b1010;
  localparam logic [3:0] SEQ_1001 = 4'b1001;

  localparam logic [1:0] SEL_1100   = 2'b00;
  localparam logic [1:0] SEL_1010   = 2'b01;
  localparam logic [1:0] SEL_1001   = 2'b10;
  localparam logic [1:0] SEL_CUSTOM = 2'b11;

  localparam int BIT_IDX_W = 2;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

  function automatic logic [3:0] select_pattern(input logic [1:0] sel,
                                                input logic [3:0] custom_pat);
    logic [3:0] pat;
    pat = custom_pat;
    case (sel)
      SEL_1100: pat = SEQ_1100;
      SEL_1010: pat = SEQ_1010;
      SEL_1001: pat = SEQ_1001;
      default:  pat = custom_pat;
    endcase
    return pat;
  endfunction

  // True when a 4-bit window matches one of the sequences the detector looks for.
  function automatic logic is_target(input logic [3:0] window);
    return (window == SEQ_1100) || (window == SEQ_1010) || (window == SEQ_1001);
  endfunction

endpackage

// File: rtl/seq_tick_divider.sv
// Bit-period tick generator: one-cycle tick every TICK_DIV enabled cycles (TICK_DIV >= 2).
module seq_tick_divider #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Free-running count while enabled, wrapping on the tick; clear restarts a bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/multiple_sequence_pattern_generator.sv
// Serial stimulus transmitter for the 1100/1010/1001 sequence detector.
// Optional golden predictor output expect_y is built when SEQ_EXPECT_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, sout low
//   ST_SHIFT | sending the 4 latched pattern bits MSB-first
//   ST_GAP   | sending GAP_BITS zero bits before the next repeat
//   ST_DONE  | single cycle with done high, then back to idle
module multiple_sequence_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [3:0] custom_pat,
  input  logic       repeat_en,
  input  logic       stop,
  output logic       sout,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done
`ifdef SEQ_EXPECT_EN
  ,
  output logic       expect_y
`endif
);

  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  seq_state_t           state, state_nxt;
  logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [3:0]           pat, pat_nxt;
  logic [3:0]           shreg, shreg_nxt;
  logic                 stop_pending, stop_pending_nxt;
  logic                 sout_nxt, strobe_nxt, busy_nxt, done_nxt;
  logic                 tick, div_clear;

  assign div_clear = (state == ST_IDLE) && start;

  seq_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(busy),
    .clear (div_clear),
    .tick  (tick)
  );

  // State and output registers; every output is registered so it is glitch-free on the board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      gap_cnt      <= '0;
      pat          <= '0;
      shreg        <= '0;
      stop_pending <= 1'b0;
      sout         <= 1'b0;
      bit_strobe   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_idx      <= bit_idx_nxt;
      gap_cnt      <= gap_cnt_nxt;
      pat          <= pat_nxt;
      shreg        <= shreg_nxt;
      stop_pending <= stop_pending_nxt;
      sout         <= sout_nxt;
      bit_strobe   <= strobe_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Next-state logic: bits advance on divider ticks; stop only takes effect at pattern/gap ends.
  always_comb begin
    state_nxt        = state;
    bit_idx_nxt      = bit_idx;
    gap_cnt_nxt      = gap_cnt;
    pat_nxt          = pat;
    shreg_nxt        = shreg;
    stop_pending_nxt = stop_pending | (busy & stop);
    sout_nxt         = sout;
    strobe_nxt       = 1'b0;
    busy_nxt         = busy;
    done_nxt         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pat_nxt          = select_pattern(sel, custom_pat);
          shreg_nxt        = pat_nxt;
          sout_nxt         = pat_nxt[3];
          strobe_nxt       = 1'b1;
          busy_nxt         = 1'b1;
          bit_idx_nxt      = '0;
          stop_pending_nxt = stop;
          state_nxt        = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (bit_idx != LAST_BIT_IDX) begin
            bit_idx_nxt = bit_idx + 1'b1;
            shreg_nxt   = {shreg[2:0], 1'b0};
            sout_nxt    = shreg[2];
            strobe_nxt  = 1'b1;
          end else if (repeat_en && !stop_pending) begin
            strobe_nxt = 1'b1;
            if (GAP_BITS > 0) begin
              state_nxt   = ST_GAP;
              gap_cnt_nxt = '0;
              sout_nxt    = 1'b0;
            end else begin
              shreg_nxt   = pat;
              sout_nxt    = pat[3];
              bit_idx_nxt = '0;
            end
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            sout_nxt  = 1'b0;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt_nxt = gap_cnt + 1'b1;
            sout_nxt    = 1'b0;
            strobe_nxt  = 1'b1;
          end else if (!stop_pending) begin
            state_nxt   = ST_SHIFT;
            shreg_nxt   = pat;
            sout_nxt    = pat[3];
            bit_idx_nxt = '0;
            strobe_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            sout_nxt  = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        sout_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

`ifdef SEQ_EXPECT_EN
  logic [2:0] history;

  // Predict the detector output alongside each new bit; history spans runs and gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history  <= '0;
      expect_y <= 1'b0;
    end else if (strobe_nxt) begin
      history  <= {history[1:0], sout_nxt};
      expect_y <= is_target({history, sout_nxt});
    end else if (done_nxt) begin
      expect_y <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_multiple_sequence_pattern_generator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_multiple_sequence_pattern_generator;

  localparam int TD = 4;
  localparam int GB = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start_b = 1'b0;
  logic       repeat_en = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] custom_pat = 4'h0;
  logic       sout, bit_strobe, busy, done;
  logic       sout_b, strobe_b, busy_b, done_b;
`ifdef SEQ_EXPECT_EN
  logic       expect_y, expect_y_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multiple_sequence_pattern_generator #(.TICK_DIV(TD), .GAP_BITS(GB)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .custom_pat(custom_pat),
    .repeat_en(repeat_en), .stop(stop), .sout(sout), .bit_strobe(bit_strobe),
    .busy(busy), .done(done)
`ifdef SEQ_EXPECT_EN
    , .expect_y(expect_y)
`endif
  );

  multiple_sequence_pattern_generator #(.TICK_DIV(2), .GAP_BITS(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .sel(sel), .custom_pat(custom_pat),
    .repeat_en(repeat_en), .stop(stop), .sout(sout_b), .bit_strobe(strobe_b),
    .busy(busy_b), .done(done_b)
`ifdef SEQ_EXPECT_EN
    , .expect_y(expect_y_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pattern_of(input logic [1:0] s, input logic [3:0] c);
    case (s)
      2'b00:   return 4'b1100;
      2'b01:   return 4'b1010;
      2'b10:   return 4'b1001;
      default: return c;
    endcase
  endfunction

  // Reference model for dut: a queue of symbols still to send; m_exp = {sout, strobe, busy, done}.
  typedef enum {M_IDLE, M_RUN, M_END} mode_t;
  mode_t      m_mode = M_IDLE;
  bit         m_q[$];
  bit         m_gap_seg = 1'b0;
  bit         m_stop = 1'b0;
  int         m_hold = 0;
  logic [3:0] m_pat = 4'h0;
  logic [3:0] m_exp = 4'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_exp  = 4'h0;
      m_stop = 1'b0;
      m_hold = 0;
      m_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_exp = 4'h0;
          if (start) begin
            m_pat = pattern_of(sel, custom_pat);
            m_stop = stop;
            m_gap_seg = 1'b0;
            m_hold = 0;
            m_q.delete();
            for (int j = 3; j >= 0; j--) m_q.push_back(m_pat[j]);
            m_exp = {m_q.pop_front(), 3'b110};
            m_mode = M_RUN;
          end
        end
        M_END: begin
          m_exp = 4'h0;
          m_mode = M_IDLE;
        end
        default: begin
          m_exp[2] = 1'b0;
          if (m_hold < TD - 1) begin
            m_hold++;
          end else begin
            m_hold = 0;
            if (m_q.size() == 0) begin
              if (!m_gap_seg && repeat_en && !m_stop) begin
                if (GB > 0) begin
                  for (int j = 0; j < GB; j++) m_q.push_back(1'b0);
                  m_gap_seg = 1'b1;
                end else begin
                  for (int j = 3; j >= 0; j--) m_q.push_back(m_pat[j]);
                end
              end else if (m_gap_seg && !m_stop) begin
                for (int j = 3; j >= 0; j--) m_q.push_back(m_pat[j]);
                m_gap_seg = 1'b0;
              end
            end
            if (m_q.size() == 0) begin
              m_exp = 4'b0001;
              m_mode = M_END;
            end else begin
              m_exp = {m_q.pop_front(), 3'b110};
            end
          end
          m_stop = m_stop | stop;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison of dut against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && reset) check("model", {sout, bit_strobe, busy, done}, m_exp);
  end

  // Directed stream check: syms holds the expected symbols MSB-first, each held td cycles.
  task automatic run_stream(input string tag, input bit on_b, input int td,
                            input logic [15:0] syms, input int nsym, input logic [15:0] ymask,
                            input int stop_at, input int restart_at);
    logic [3:0] got;
    logic [3:0] exp;
    int last;
    last = nsym * td;
    if (on_b) start_b = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i <= last + 1; i++) begin
      got = on_b ? {sout_b, strobe_b, busy_b, done_b} : {sout, bit_strobe, busy, done};
      if (i < last) exp = {syms[15 - i / td], (i % td) == 0, 1'b1, 1'b0};
      else if (i == last) exp = 4'b0001;
      else exp = 4'b0000;
      check(tag, got, exp);
`ifdef SEQ_EXPECT_EN
      if (on_b && i < last) check({tag, "_y"}, expect_y_b, ymask[15 - i / td]);
`endif
      if (i == stop_at) stop = 1'b1;
      start = (i == restart_at);
      @(negedge clk);
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_a", {sout, bit_strobe, busy, done}, 4'h0);
    check("reset_b", {sout_b, strobe_b, busy_b, done_b}, 4'h0);
`ifdef SEQ_EXPECT_EN
    check("reset_y", expect_y, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    sel = 2'b00;
    run_stream("t1_1100", 1'b0, TD, 16'hC000, 4, 16'h0, -1, -1);

    sel = 2'b11; custom_pat = 4'b1001; repeat_en = 1'b1;
    run_stream("t2_rep", 1'b0, TD, 16'h9240, 10, 16'h0, 28, -1);
    repeat_en = 1'b0;

    sel = 2'b01;
    run_stream("t3_ignore", 1'b0, TD, 16'hA000, 4, 16'h0, -1, 5);

    sel = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("t4_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1 check("t4_async", {sout, bit_strobe, busy, done}, 4'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    run_stream("t4_1001", 1'b0, TD, 16'h9000, 4, 16'h0, -1, -1);

    sel = 2'b01; repeat_en = 1'b1;
    run_stream("t5_b2b", 1'b1, 2, 16'hAA00, 8, 16'h1500, 9, -1);
    repeat_en = 1'b0;

    sel = 2'b00;
    run_stream("t6_div2", 1'b1, 2, 16'hC000, 4, 16'h0, -1, -1);

    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) repeat_en = ~repeat_en;
      sel = 2'($urandom);
      custom_pat = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1; repeat_en = 1'b0;
    repeat (60) @(negedge clk);
    check("drained", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
